// File: rtl/soc_system_janela_addr_gen_if.sv
// ---------------------------------------------------------------------------
// soc_system_janela_addr_gen_if
//   Address-stream handshake between the window address generator (master)
//   and the pixel-fetch / memory-read stage (slave).
//
//   addr        master->slave  ADDR_W  current pixel address
//   addr_valid  master->slave  1       addr is valid this cycle
//   addr_ready  slave->master  1       slave accepts addr this cycle
// ---------------------------------------------------------------------------
interface soc_system_janela_addr_gen_if #(
    parameter int unsigned ADDR_W = 17
);
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              addr_ready;

    modport master (
        output addr,
        output addr_valid,
        input  addr_ready
    );

    modport slave (
        input  addr,
        input  addr_valid,
        output addr_ready
    );
endinterface

// File: rtl/soc_system_janela_addr_gen.sv
// ---------------------------------------------------------------------------
// soc_system_janela_addr_gen
//   Emits the row-major pixel address stream of one W x H window anchored at
//   base_addr inside a frame IMG_W pixels wide. W/H come from the janela_dim
//   PIO word ([15:0]=W, [31:16]=H) and are latched on start in IDLE.
//
//   Ports:
//     clk         system clock
//     reset_n     asynchronous active-low reset
//     janela_dim  window dimensions from the PIO
//     base_addr   address of the window's top-left pixel
//     start       one-cycle request, sampled only in IDLE
//     addr_if     master side of the addr/addr_valid/addr_ready handshake
//     busy        high in RUN and DONE
//     done        one-cycle pulse after the last address is accepted
//     err         one-cycle pulse on an illegal dimension
//
//   Build option JANELA_DIM_CLAMP_EN:
//     defined   -> W/H clamped to 1..MAX_WIN at latch, err never asserts
//     undefined -> W/H of 0 or >MAX_WIN rejected with an err pulse
// ---------------------------------------------------------------------------
module soc_system_janela_addr_gen #(
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned IMG_W   = 320,
    parameter int unsigned MAX_WIN = 16
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [31:0]                           janela_dim,
    input  logic [ADDR_W-1:0]                     base_addr,
    input  logic                                  start,
    soc_system_janela_addr_gen_if.master          addr_if,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);

    localparam int unsigned       CNT_W  = $clog2(MAX_WIN + 1);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_W);
    localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  w_q, h_q;
    logic [CNT_W-1:0]  r, c;
    logic [ADDR_W-1:0] row_base;

    logic [15:0]       w_fld, h_fld;
    logic [CNT_W-1:0]  w_eff, h_eff;
    logic              dims_ok;

    assign w_fld = janela_dim[15:0];
    assign h_fld = janela_dim[31:16];

    always_comb begin
        w_eff   = '0;
        h_eff   = '0;
        dims_ok = 1'b0;
`ifdef JANELA_DIM_CLAMP_EN
        if (w_fld == 16'd0)
            w_eff = ONE;
        else if (32'(w_fld) > MAX_WIN)
            w_eff = CNT_W'(MAX_WIN);
        else
            w_eff = w_fld[CNT_W-1:0];
        if (h_fld == 16'd0)
            h_eff = ONE;
        else if (32'(h_fld) > MAX_WIN)
            h_eff = CNT_W'(MAX_WIN);
        else
            h_eff = h_fld[CNT_W-1:0];
        dims_ok = 1'b1;
`else
        w_eff   = w_fld[CNT_W-1:0];
        h_eff   = h_fld[CNT_W-1:0];
        dims_ok = (w_fld != 16'd0) && (32'(w_fld) <= MAX_WIN) &&
                  (h_fld != 16'd0) && (32'(h_fld) <= MAX_WIN);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            w_q                <= '0;
            h_q                <= '0;
            r                  <= '0;
            c                  <= '0;
            row_base           <= '0;
            addr_if.addr       <= '0;
            addr_if.addr_valid <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w_q <= w_eff;
                        h_q <= h_eff;
                        if (dims_ok) begin
                            row_base           <= base_addr;
                            addr_if.addr       <= base_addr;
                            r                  <= '0;
                            c                  <= '0;
                            addr_if.addr_valid <= 1'b1;
                            busy               <= 1'b1;
                            state              <= RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (addr_if.addr_valid && addr_if.addr_ready) begin
                        if (c == w_q - ONE) begin
                            if (r == h_q - ONE) begin
                                addr_if.addr_valid <= 1'b0;
                                done               <= 1'b1;
                                state              <= DONE;
                            end else begin
                                // Next row starts one stride below the current row
                                // start; sums wrap modulo 2^ADDR_W.
                                c            <= '0;
                                r            <= r + ONE;
                                row_base     <= row_base + STRIDE;
                                addr_if.addr <= row_base + STRIDE;
                            end
                        end else begin
                            c            <= c + ONE;
                            addr_if.addr <= addr_if.addr + ADDR_W'(1);
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    addr_if.addr_valid <= 1'b0;
                    busy               <= 1'b0;
                    done               <= 1'b0;
                    state              <= IDLE;
                end
            endcase
        end
    end

endmodule
